// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes driven into yAlu, ALUOp/funct encodings
// produced by the decoder, and the entry/occupancy types of the issue stage.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_RSVD   = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // Decoded control carried alongside the operands of each entry
   typedef struct packed {
      logic [2:0] op;
      logic       illegal;
   } alu_ctrl_t;

   // Full entry as seen by a default-width ALU consumer
   typedef struct packed {
      logic [ALU_WIDTH-1:0] a;
      logic [ALU_WIDTH-1:0] b;
      logic [2:0]           op;
      logic                 illegal;
   } alu_entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct to ALU operation decoder. Unsupported encodings
// fall back to AND and raise the illegal flag; the entry is still issued.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output alu_ctrl_t  ctrl
);

   // Map the ALUOp class (and funct for R-type) onto the 3-bit ALU op
   always_comb begin
      ctrl.op      = ALU_AND;
      ctrl.illegal = 1'b0;
      case (aluop)
         ALUOP_MEM:    ctrl.op = ALU_ADD;
         ALUOP_BRANCH: ctrl.op = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: ctrl.op = ALU_ADD;
               FUNCT_SUB: ctrl.op = ALU_SUB;
               FUNCT_AND: ctrl.op = ALU_AND;
               FUNCT_OR:  ctrl.op = ALU_OR;
               FUNCT_SLT: ctrl.op = ALU_SLT;
               default:   ctrl.illegal = 1'b1;
            endcase
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage in front of yAlu: decodes the ALU op, selects operand B
// and buffers entries in a small circular FIFO whose head drives the ALU.
// Optional feature macro: ALU_ISSUE_STATS_EN adds the issue_cnt pop counter.
module alu_issue
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int DEPTH = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_aluop,
   input  logic [5:0]       in_funct,
   input  logic [WIDTH-1:0] in_rs_val,
   input  logic [WIDTH-1:0] in_rt_val,
   input  logic [15:0]      in_imm,
   input  logic             in_alusrc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [2:0]       out_op,
   output logic             out_illegal
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [31:0]      issue_cnt
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      alu_ctrl_t        ctrl;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        new_entry;
   entry_t        head;
   alu_ctrl_t     dec_ctrl;
   occ_state_e    occ;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   alu_op_decode u_decode (
      .aluop (in_aluop),
      .funct (in_funct),
      .ctrl  (dec_ctrl)
   );

   // Assemble the entry to store: operand A is rs, B is rt or the sign-extended immediate
   always_comb begin
      new_entry.a    = in_rs_val;
      new_entry.b    = in_alusrc ? WIDTH'($signed(in_imm)) : in_rt_val;
      new_entry.ctrl = dec_ctrl;
   end

   // Classify occupancy from the registered count so in_ready never sees out_ready
   always_comb begin
      if (count == '0)
         occ = OCC_EMPTY;
      else if (count == CW'(DEPTH))
         occ = OCC_FULL;
      else
         occ = OCC_PARTIAL;
   end

   assign in_ready  = (occ != OCC_FULL);
   assign out_valid = (occ != OCC_EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // FIFO storage, pointers and occupancy; reset discards every buffered entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= new_entry;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop)
            rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   assign head        = mem[rd_ptr];
   assign out_a       = head.a;
   assign out_b       = head.b;
   assign out_op      = head.ctrl.op;
   assign out_illegal = head.ctrl.illegal;

`ifdef ALU_ISSUE_STATS_EN
   // Count every entry handed to the ALU; wraps naturally at 32 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         issue_cnt <= '0;
      else if (pop)
         issue_cnt <= issue_cnt + 32'd1;
   end
`endif

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue stage directly upstream of the 32-bit ALU (`yAlu`). Accepts decoded-instruction fields over a valid/ready handshake, generates the 3-bit ALU operation from ALUOp/funct, selects operand B (register or sign-extended immediate), and buffers up to DEPTH entries. It presents `a`, `b`, `op` to the ALU with one cycle of latency and flags unsupported encodings.

## Interface
- WIDTH, 32, operand width
- DEPTH, 2, buffer entries; must be at least 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; high when occupancy < DEPTH
- in_aluop  in  2  00 = load/store add, 01 = branch subtract, 10 = R-type (use funct), 11 = reserved
- in_funct  in  6  R-type function field
- in_rs_val  in  WIDTH  register rs value
- in_rt_val  in  WIDTH  register rt value
- in_imm  in  16  immediate
- in_alusrc  in  1  1 = B comes from sign-extended in_imm, 0 = B comes from in_rt_val
- out_valid  out  1  head entry valid
- out_ready  in  1  ALU side consumes head
- out_a  out  WIDTH  operand A (rs)
- out_b  out  WIDTH  operand B
- out_op  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
- out_illegal  out  1  head entry had an unsupported encoding
- issue_cnt  out  32  issued-entry count (only with the macro)

## Operation
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- ALU op decode (done at push, stored in the entry):
  - aluop 00 → 010
  - aluop 01 → 110
  - aluop 10 with funct 100000 → 010
  - aluop 10 with funct 100010 → 110
  - aluop 10 with funct 100100 → 000
  - aluop 10 with funct 100101 → 001
  - aluop 10 with funct 101010 → 111
  - Any other funct, or aluop 11 → op 000 and illegal = 1. The entry is still issued.
- Operand B: `alusrc ? {{16{imm[15]}}, imm} : rt_val` (for WIDTH > 16, replicate the sign bit to fill WIDTH).
- Buffer is a circular FIFO: wr_ptr and rd_ptr wrap at DEPTH-1 → 0, plus an occupancy counter.
- Occupancy states:
  - EMPTY: out_valid = 0
  - PARTIAL: 0 < count < DEPTH
  - FULL: in_ready = 0
- Transitions:
  - Push only: count + 1
  - Pop only: count − 1
  - Push and pop in the same cycle: count unchanged, pointers both advance
- in_ready depends only on registered count, never combinationally on out_ready. When FULL, a same-cycle pop does not allow a push that cycle.
- Outputs are driven from the head entry registers. The head is stable while `out_valid && !out_ready`.

## Timing
- Latency: an entry pushed in cycle N is visible at the outputs (out_valid = 1) in cycle N+1 when the buffer was empty.
- Throughput: one entry per cycle in steady state when out_ready is held high.
- Reset values (asynchronous, immediate on rst_n low):
  - count 0 and both pointers 0
  - out_valid 0, in_ready 1
  - out_a, out_b, out_op, out_illegal all 0
  - issue_cnt 0
- Reset asserted mid-operation discards all buffered entries. No partial pop is observed.
- Outputs other than out_valid are don't-care while out_valid = 0. The bench must not check them.

## Configuration
- ALU_ISSUE_STATS_EN defined:
  - issue_cnt increments by 1 on every pop.
  - Wraps from 32'hFFFFFFFF to 0.
- ALU_ISSUE_STATS_EN undefined:
  - The issue_cnt port is absent and no counter logic is built.
  - All other behaviour is identical.

## Structure
- Shared package `alu_pkg` holds:
  - ALU op constants: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111
  - ALUOp codes and funct constants
  - Entry typedef {a, b, op, illegal}
- The `yAlu` testbench reuses the same op constants.
- One sub-module: `alu_op_decode`, a combinational aluop/funct → {op, illegal} decoder. FIFO storage stays inline.

## Test plan
- Reset, then push one entry with aluop 10, funct 100100, rs=32'hF0F0_0000, rt=32'h0FF0_FFFF, alusrc 0 → next cycle out_valid 1, op 000, a/b unchanged, illegal 0. Feeding the outputs to yAlu gives z = 32'h00F0_0000.
- Push with aluop 00, alusrc 1, imm 16'hFFFC → out_op 010, out_b = 32'hFFFF_FFFC.
- Hold out_ready 0 and push 3 times → in_ready drops after the 2nd push; the 3rd is not accepted; the head stays equal to entry 1.
- In the full state, assert out_ready and in_valid together → one pop, no push that cycle; the push is accepted the following cycle; order is preserved (1, 2, 3).
- Push aluop 10 with funct 000000, then aluop 11 → both issue with op 000 and illegal 1. Push aluop 10 with funct 101010 → op 111, illegal 0.
- Assert rst_n low while 2 entries are buffered → out_valid 0 immediately, in_ready 1. With ALU_ISSUE_STATS_EN defined, issue_cnt = 0 after reset and equals 5 after 5 pops.
